// File: rtl/gpio_link_tx.sv
// Sender end of the 4-wire req/ack GPIO link: serialises a WIDTH-bit word into
// MSB-first tribits using a four-phase handshake with an ack-timeout abort.
module gpio_link_tx #(
    parameter int WIDTH          = 12,
    parameter int SETUP_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [3:0]       link_data,
    input  logic             link_ack,
    output logic             busy,
    output logic             tx_done,
    output logic             timeout,
    output logic             err
);

    localparam int NT      = WIDTH / 3;
    localparam int IW      = (NT > 1) ? $clog2(NT) : 1;
    localparam int CNT_TOP = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
    localparam int CW      = $clog2(CNT_TOP + 1);

    localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, REQ, REL} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shift_q, shift_next, shift_adv;
    logic [IW-1:0]    idx_q, idx_next;
    logic [CW-1:0]    cnt_q, cnt_next, cnt_inc;
    logic [3:0]       link_next;
    logic             done_next, timeout_next, err_next;
    logic             ack_meta, ack_s;

    // The ack wire comes from another board, so it is only used after two flops.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= link_ack;
            ack_s    <= ack_meta;
        end
    end

    assign tx_ready  = (state == IDLE) && !ack_s;
    assign busy      = (state != IDLE);
    assign shift_adv = shift_q << 3;
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            link_data <= 4'b0000;
            tx_done   <= 1'b0;
            timeout   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            shift_q   <= shift_next;
            idx_q     <= idx_next;
            cnt_q     <= cnt_next;
            link_data <= link_next;
            tx_done   <= done_next;
            timeout   <= timeout_next;
            err       <= err_next;
        end
    end

    // Next-state logic also produces the next value of every pin so the pins come straight off flops.
    always_comb begin
        state_next   = state;
        shift_next   = shift_q;
        idx_next     = idx_q;
        cnt_next     = cnt_q;
        link_next    = link_data;
        done_next    = 1'b0;
        timeout_next = 1'b0;
        err_next     = err;

        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    shift_next = tx_data;
                    idx_next   = IDX_LAST;
                    cnt_next   = '0;
                    link_next  = {1'b0, tx_data[WIDTH-1 -: 3]};
                    state_next = SETUP;
                end
            end

            SETUP: begin
                if (cnt_q >= SETUP_LAST) begin
                    cnt_next     = '0;
                    link_next[3] = 1'b1;
                    state_next   = REQ;
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            // A seen ack takes priority over a timeout expiring in the same cycle.
            REQ: begin
                if (ack_s) begin
                    cnt_next     = '0;
                    link_next[3] = 1'b0;
                    state_next   = REL;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    cnt_next     = '0;
                    link_next    = 4'b0000;
                    timeout_next = 1'b1;
                    err_next     = 1'b1;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            REL: begin
                if (!ack_s) begin
                    cnt_next = '0;
                    if (idx_q == '0) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        shift_next = shift_adv;
                        idx_next   = idx_q - 1'b1;
                        link_next  = {1'b0, shift_adv[WIDTH-1 -: 3]};
                        state_next = SETUP;
                    end
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    cnt_next     = '0;
                    link_next    = 4'b0000;
                    timeout_next = 1'b1;
                    err_next     = 1'b1;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
